des_key_schedule: RTL and testbench

- Generates the sixteen 48-bit DES round subkeys from a 64-bit key, one round at a time.
- Sits directly upstream of the round-function permutation stage and feeds it one subkey per round over a valid/ready handshake.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1) without precomputing or storing all subkeys.

---
 rtl/des_key_schedule.sv | 228 ++++++++++++++++++++++
 tb/tb_des_key_schedule.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
//
// Produces the sixteen 48-bit DES round subkeys from a 64-bit key, one per
// round. Subkeys are handed downstream over a valid/ready handshake in
// encrypt order (K1..K16) or decrypt order (K16..K1). Only the 56-bit C/D
// state is kept. Each next subkey is made by rotating C/D in place, so the
// full set of subkeys is never stored.
//
// Optional build macro: DES_KS_PARITY_CHECK_EN
//   When defined, a start request checks the odd parity of every key byte.
//   A bad key is rejected and flagged on parity_err.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   start       load key and begin a schedule (honoured only in IDLE)
//   decrypt     sampled with start: 0 = K1..K16, 1 = K16..K1
//   key[63:0]   DES key, key[63] is FIPS bit 1
//   sk_valid    subkey / sk_round valid
//   sk_ready    downstream accepts the current subkey
//   subkey      PC-2 of the current C/D registers
//   sk_round    emission index 0..15
//   busy        high in LOAD, ROUND and DONE
//   done        one-cycle pulse after the last handshake
//   parity_err  key byte parity failure (only with DES_KS_PARITY_CHECK_EN)
//
// States:
//   state | meaning
//   IDLE  | waiting for start; C/D loaded from PC-1(key) on accept
//   LOAD  | first rotation (left 1 for encrypt, none for decrypt)
//   ROUND | present subkeys; rotate C/D on each handshake
//   DONE  | done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module des_key_schedule #(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [47:0] subkey,
    output logic [3:0]  sk_round,
    output logic        busy,
    output logic        done
`ifdef DES_KS_PARITY_CHECK_EN
    ,
    output logic        parity_err
`endif
);

    // Permutation tables in FIPS numbering (bit 1 = MSB).
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) begin
            o[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
        end
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) begin
            o[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
        end
        return o;
    endfunction

    function automatic logic [27:0] rot_l(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rot_r(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    state_t      r_state;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic        r_dec;
    logic [3:0]  r_cnt;
    logic        r_sk_valid;
    logic        r_busy;
    logic        r_done;

    logic [55:0] w_pc1;
    logic [27:0] w_c_next;
    logic [27:0] w_d_next;
    logic        w_one_shift;
    logic        w_parity_ok;

    assign w_pc1 = pc1(key);

    // Single-position rotations sit between emitted indices 0/1, 7/8 and
    // 14/15. The encrypt and decrypt tables line up on the same indices.
    assign w_one_shift = (r_cnt == 4'd0) || (r_cnt == 4'd7) || (r_cnt == 4'd14);

    always_comb begin
        w_c_next = r_c;
        w_d_next = r_d;
        if (r_dec) begin
            w_c_next = rot_r(r_c, w_one_shift);
            w_d_next = rot_r(r_d, w_one_shift);
        end else begin
            w_c_next = rot_l(r_c, w_one_shift);
            w_d_next = rot_l(r_d, w_one_shift);
        end
    end

`ifdef DES_KS_PARITY_CHECK_EN
    logic [7:0] w_byte_par;
    logic       r_parity_err;

    for (genvar g = 0; g < 8; g++) begin : g_par
        assign w_byte_par[g] = ^key[8*g +: 8];
    end

    assign w_parity_ok = &w_byte_par;
    assign parity_err  = r_parity_err;
`else
    // Parity bits are don't-care in this build.
    logic w_unused_par;
    assign w_unused_par = ^{key[56], key[48], key[40], key[32],
                            key[24], key[16], key[8],  key[0]};
    assign w_parity_ok  = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_c        <= '0;
            r_d        <= '0;
            r_dec      <= 1'b0;
            r_cnt      <= '0;
            r_sk_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef DES_KS_PARITY_CHECK_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_sk_valid <= 1'b0;
`ifdef DES_KS_PARITY_CHECK_EN
                    if (start) begin
                        r_parity_err <= !w_parity_ok;
                    end
`endif
                    if (start && w_parity_ok) begin
                        r_dec   <= decrypt;
                        r_c     <= w_pc1[55:28];
                        r_d     <= w_pc1[27:0];
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Decrypt starts at C16D16, which equals PC-1 itself.
                    if (!r_dec) begin
                        r_c <= rot_l(r_c, 1'b1);
                        r_d <= rot_l(r_d, 1'b1);
                    end
                    r_cnt   <= '0;
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    if (!r_sk_valid) begin
                        r_sk_valid <= 1'b1;
                    end else if (sk_ready) begin
                        if (r_cnt == LAST_ROUND) begin
                            r_sk_valid <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                            r_c   <= w_c_next;
                            r_d   <= w_d_next;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign subkey   = pc2({r_c, r_d});
    assign sk_round = r_cnt;
    assign sk_valid = r_sk_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

    localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B   = 64'h0123456789ABCDEF;
    localparam logic [63:0] KEY_X   = 64'h0E329232EA6D0D73;
    localparam logic [47:0] KA_K1   = 48'h1B02EFFC7072;
    localparam logic [47:0] KA_K2   = 48'h79AED9DBC9E5;
    localparam logic [47:0] KA_K16  = 48'hCB3D8B0E17F5;

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic        sk_valid;
    logic        sk_ready;
    logic [47:0] subkey;
    logic [3:0]  sk_round;
    logic        busy;
    logic        done;
`ifdef DES_KS_PARITY_CHECK_EN
    logic        parity_err;
`endif

    int          n_total = 0;
    int          n_bad   = 0;
    logic [47:0] got [16];

    des_key_schedule #(.ROUNDS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .decrypt    (decrypt),
        .key        (key),
        .sk_valid   (sk_valid),
        .sk_ready   (sk_ready),
        .subkey     (subkey),
        .sk_round   (sk_round),
        .busy       (busy),
        .done       (done)
`ifdef DES_KS_PARITY_CHECK_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    // Textbook key schedule: K_r = PC-2 of C0/D0 left-rotated by the
    // cumulative shift count up to round r (1-based).
    function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int r);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] o;
        int          s;
        cd = '0;
        o  = '0;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
        c = cd[55:28];
        d = cd[27:0];
        s = 0;
        for (int j = 0; j < r; j++) s += SHIFTS[j];
        for (int j = 0; j < s; j++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
        return o;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, obs, exp_v);
        end
    endtask

    // One schedule. rnd: random sk_ready. poke_hs: pulse start with another
    // key at that handshake count. rst_hs: reset for one cycle at that count.
    task automatic run(input logic [63:0] k, input logic dec, input logic rnd,
                       input int poke_hs, input int rst_hs);
        int          hs;
        int          cyc;
        int          first_valid;
        int          end_cyc;
        int          done_cnt;
        logic [47:0] exp_k;
        hs = 0; first_valid = -1; end_cyc = -1; done_cnt = 0;
        @(negedge clk);
        key = k; decrypt = dec; start = 1'b1; sk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; key = KEY_X; decrypt = ~dec;
        for (cyc = 0; cyc < 400; cyc++) begin
            if (!busy) begin
                end_cyc = cyc;
                break;
            end
            if (done) done_cnt++;
            if (sk_valid && first_valid < 0) first_valid = cyc;
            if (sk_valid) begin
                exp_k = ref_subkey(k, dec ? (16 - hs) : (hs + 1));
                check_val("subkey", 64'(subkey), 64'(exp_k));
                check_val("sk_round", 64'(sk_round), 64'(hs));
            end
            if (sk_valid && hs == rst_hs) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check_val("rst_sk_valid", 64'(sk_valid), 64'd0);
                check_val("rst_busy", 64'(busy), 64'd0);
                check_val("rst_subkey", 64'(subkey), 64'd0);
                check_val("rst_sk_round", 64'(sk_round), 64'd0);
                check_val("rst_done", 64'(done), 64'd0);
                return;
            end
            start = (sk_valid && hs == poke_hs) ? 1'b1 : 1'b0;
            if (start) key = KEY_B;
            sk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sk_valid && sk_ready) begin
                if (hs < 16) got[hs] = subkey;
                hs++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_val("timeout", 64'(end_cyc < 0), 64'd0);
        check_val("handshakes", 64'(hs), 64'd16);
        check_val("done_pulses", 64'(done_cnt), 64'd1);
        check_val("first_valid", 64'(first_valid), 64'd2);
        if (!rnd) check_val("cycles", 64'(end_cyc), 64'd19);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; key = KEY_A; sk_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_sk_valid", 64'(sk_valid), 64'd0);
        check_val("reset_busy", 64'(busy), 64'd0);
        check_val("reset_done", 64'(done), 64'd0);
        check_val("reset_subkey", 64'(subkey), 64'd0);
        check_val("reset_sk_round", 64'(sk_round), 64'd0);
        rst_n = 1'b1;

        run(KEY_A, 1'b0, 1'b0, -1, -1);
        check_val("enc_k1", 64'(got[0]), 64'(KA_K1));
        check_val("enc_k2", 64'(got[1]), 64'(KA_K2));
        check_val("enc_k16", 64'(got[15]), 64'(KA_K16));

        run(KEY_A, 1'b1, 1'b0, -1, -1);
        check_val("dec_first", 64'(got[0]), 64'(KA_K16));
        check_val("dec_second", 64'(got[1]), 64'(48'hBF918D3D3F0A));
        check_val("dec_last", 64'(got[15]), 64'(KA_K1));

        run(KEY_A, 1'b0, 1'b1, -1, -1);
        run(KEY_B, 1'b1, 1'b1, -1, -1);

        run(KEY_A, 1'b0, 1'b0, 5, -1);
        check_val("poke_k16", 64'(got[15]), 64'(KA_K16));

        run(KEY_A, 1'b0, 1'b0, -1, 8);
        run(KEY_A, 1'b0, 1'b0, -1, -1);
        check_val("post_rst_k1", 64'(got[0]), 64'(KA_K1));

`ifdef DES_KS_PARITY_CHECK_EN
        @(negedge clk);
        key = 64'h133457799BBCDFF0; decrypt = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("par_err_set", 64'(parity_err), 64'd1);
        check_val("par_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check_val("par_no_valid", 64'(sk_valid), 64'd0);
        check_val("par_err_hold", 64'(parity_err), 64'd1);
        run(KEY_A, 1'b0, 1'b0, -1, -1);
        check_val("par_err_clr", 64'(parity_err), 64'd0);
        check_val("par_k1", 64'(got[0]), 64'(KA_K1));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
